// File: rtl/uart_tx_ext.sv
//==============================================================================
// Module   : uart_tx_ext
// Purpose  : UART transmitter with runtime baud divider, optional parity,
//            one or two stop bits and an optional input FIFO.
//            Frame: start(0), data LSB first, [parity], stop(1) x STOP_BITS.
// Ports    : clock        - rising-edge clock
//            reset        - synchronous, active-high reset
//            baud_divider - clocks per bit, sampled at frame start (0 -> 1)
//            data_valid   - source offers a word
//            data_ready   - block accepts a word this cycle
//            data_bits    - word to send, LSB first
//            busy         - frame in progress or FIFO non-empty
//            fifo_level   - FIFO occupancy (tied to 0 without FIFO)
//            tx           - serial line, idle high
// Config   : define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry input FIFO.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_tx_ext #(
   parameter int NUMBER_OF_BITS = 8,
   parameter int DIVIDER_BITS   = 16,
   parameter int PARITY         = 0,
   parameter int STOP_BITS      = 1,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [DIVIDER_BITS-1:0]           baud_divider,
   input  logic                              data_valid,
   output logic                              data_ready,
   input  logic [NUMBER_OF_BITS-1:0]         data_bits,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              tx
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W = $clog2(NUMBER_OF_BITS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                    state_q, state_d;
   logic [DIVIDER_BITS-1:0]   div_q, div_d;
   logic [DIVIDER_BITS-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]          bit_q, bit_d;
   logic                      stop_q, stop_d;
   logic [NUMBER_OF_BITS-1:0] shift_q, shift_d;
   logic                      par_q, par_d;
   logic                      tx_q, tx_d;

   logic                      w_bit_end;
   logic                      w_last_stop;
   logic                      w_load_ok;
   logic                      w_src_valid;
   logic                      w_src_pop;
   logic [NUMBER_OF_BITS-1:0] w_src_data;
   logic                      w_src_par;
   logic                      w_fifo_busy;

   // Bit timing: every bit lasts div_q clocks, div_q is frozen for the frame.
   assign w_bit_end   = (cnt_q == (div_q - DIVIDER_BITS'(1)));
   assign w_last_stop = (state_q == S_STOP) && w_bit_end &&
                        (stop_q == 1'(STOP_BITS - 1));
   // The shifter can take a new word when idle, or in the very last clock of
   // the final stop bit so that the next start bit follows with no gap.
   assign w_load_ok   = (state_q == S_IDLE) || w_last_stop;
   assign w_src_pop   = w_src_valid && w_load_ok;
   assign w_src_par   = (PARITY == 2) ? ~(^w_src_data) : (^w_src_data);

`ifdef UART_TX_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [NUMBER_OF_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]          level_q;
   logic                      w_push;

   assign data_ready  = !reset && (level_q != LVL_W'(FIFO_DEPTH));
   assign w_push      = data_valid && data_ready;
   assign w_src_valid = (level_q != '0);
   assign w_src_data  = mem_q[rd_ptr_q];
   assign w_fifo_busy = (level_q != '0);
   assign fifo_level  = level_q;

   always_ff @(posedge clock) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= data_bits;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (w_src_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({w_push, w_src_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end
`else
   // Direct handshake: the source feeds the shifter without buffering.
   assign data_ready  = !reset && w_load_ok;
   assign w_src_valid = data_valid && !reset;
   assign w_src_data  = data_bits;
   assign w_fifo_busy = 1'b0;
   assign fifo_level  = '0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= DIVIDER_BITS'(1);
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // tx is computed one clock ahead and registered, so the line never glitches.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      cnt_d   = cnt_q + DIVIDER_BITS'(1);
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;

      case (state_q)
         S_IDLE: begin
            cnt_d = cnt_q;
            tx_d  = 1'b1;
         end
         S_START: begin
            if (w_bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(NUMBER_OF_BITS - 1)) begin
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     stop_d  = 1'b0;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               state_d = S_STOP;
               cnt_d   = '0;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               cnt_d = '0;
               if (w_last_stop) begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Loading a word overrides the above: start bit begins next clock.
      if (w_src_pop) begin
         state_d = S_START;
         div_d   = (baud_divider == '0) ? DIVIDER_BITS'(1) : baud_divider;
         cnt_d   = '0;
         shift_d = w_src_data;
         par_d   = w_src_par;
         tx_d    = 1'b0;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != S_IDLE) || w_fifo_busy;

endmodule

`default_nettype wire
